fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
Instruction-fetch stage of the 5-stage MIPS pipeline. Owns the program counter and drives the word address into the combinational instruction memory. Registers the returned instruction and PC+4 into the IF/ID pipeline register consumed by decode. Handles stall from hazard detection, redirect from branch/jump resolution, and flush.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
NOP_INSTR, 32'h0000_0000, instruction placed in IF/ID on flush, redirect or reset (sll $0,$0,0).
CNT_W, 16, width of fetch counter.

Ports:
clk  input  1  rising-edge clock.
rst_n  input  1  asynchronous active-low reset.
stall  input  1  hold PC and IF/ID (load-use hazard).
flush  input  1  squash IF/ID contents next edge; PC still advances.
redirect_valid  input  1  taken branch/jump resolved this cycle.
redirect_target  input  32  new PC for redirect.
imem_addr  output  32  byte address to instruction memory; equals pc.
imem_rdata  input  32  instruction from memory (combinational from imem_addr).
if_id_instr  output  32  registered instruction to decode.
if_id_pc4  output  32  registered PC+4 of that instruction.
if_id_valid  output  1  IF/ID holds a real instruction.
misalign_err  output  1  sticky: a redirect target had nonzero bits [1:0].
fetch_count  output  CNT_W  number of instructions accepted into IF/ID.

Behaviour:
- Async reset (rst_n low): pc=RESET_PC, if_id_instr=NOP_INSTR, if_id_pc4=0, if_id_valid=0, misalign_err=0, fetch_count=0. Reset takes effect mid-operation regardless of stall/redirect.
- imem_addr = pc, combinational, no latency; instruction for pc arrives the same cycle.
- pc_plus4 = pc + 4, modulo 2^32 (32'hFFFF_FFFC wraps to 0, no flag).
- Next-PC priority per edge: redirect_valid > stall > sequential.
  redirect_valid: pc <= {redirect_target[31:2], 2'b00}.
  stall (no redirect): pc holds.
  otherwise: pc <= pc_plus4.
- IF/ID update priority per edge: redirect_valid or flush > stall > load.
  squash: if_id_instr<=NOP_INSTR, if_id_pc4<=0, if_id_valid<=0.
  stall: all IF/ID fields hold (including a held bubble).
  load: if_id_instr<=imem_rdata, if_id_pc4<=pc_plus4, if_id_valid<=1.
- Redirect with stall in the same cycle: redirect wins for both PC and IF/ID (wrong-path instruction discarded).
- flush without redirect: PC follows stall/sequential rule; only IF/ID squashed.
- Latency: instruction at pc appears on if_id_* one edge after it is presented; first valid IF/ID at the first edge after rst_n deasserts.
- fetch_count increments by 1 on every load edge only (not stall, not squash); wraps at 2^CNT_W.
- misalign_err sets on any edge where redirect_valid=1 and redirect_target[1:0]!=0; stays set until reset. The target is still used with low bits cleared.
- No X-propagation: if_id_instr is never loaded from imem_rdata on a squash or stall edge.

Decomposition:
- Shared package mips_pkg: NOP_INSTR constant, XLEN=32, INSTR_BYTES=4, and the if_id_t struct {instr, pc4, valid}, reused by decode.
- One sub-module, pc_reg: PC register with next-PC priority mux and misalign detection. fetch_stage instantiates pc_reg and holds the IF/ID register and the counter.

Test Plan:
- Reset then free-run with memory words 0x8C010007, 0x20210001, 0xAC010002 at addresses 0,4,8. Required: if_id_instr shows these three values on edges 1,2,3, with if_id_pc4 = 4, 8, 12, valid=1, and fetch_count=3.
- Stall for 2 cycles while pc=4. Required: pc holds at 4, IF/ID holds 0x8C010007/pc4=4, and fetch_count is unchanged. Sequence resumes with 0x20210001.
- redirect_valid with target 0x40 at pc=8. Required: next pc=0x40, if_id_valid=0 with instr=0, and the following edge loads mem[0x40] with pc4=0x44.
- redirect and stall asserted together with target 0x20. Required: pc=0x20 and IF/ID squashed (redirect wins).
- Redirect target 0x0000_0013. Required: pc=0x10 and misalign_err=1, which stays 1 until rst_n is pulsed low.
- Set pc to 0xFFFF_FFFC via redirect then run one edge. Required: pc=0, and if_id_pc4=0 on the following load. Assert rst_n low mid-stall: all outputs immediately return to reset values.

Source files
------------

// File: rtl/mips_pkg.sv
// Purpose: shared MIPS pipeline constants and the IF/ID register layout.
// Latency: n/a (types and constants only).
// Backpressure: n/a; decode reuses if_id_t as its input register type.
package mips_pkg;

  localparam int XLEN        = 32;
  localparam int INSTR_BYTES = 4;

  // sll $0,$0,0 encodes as all zeros; used for every bubble.
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0000;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc4;
    logic            valid;
  } if_id_t;

endpackage

// File: rtl/fetch_stage_pc_reg.sv
// Purpose: program counter with next-PC priority mux and sticky misaligned-redirect flag.
// Latency: pc updates one edge after redirect/stall are sampled; pc_plus4 is combinational.
// Backpressure: stall holds pc unless a redirect arrives in the same cycle.
// Ports: clk, rst_n | stall, redirect_valid, redirect_target in | pc, pc_plus4, misalign_err out.
module pc_reg
  import mips_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus4,
  output logic            misalign_err
);

  // Wraps silently at the top of the address space.
  assign pc_plus4 = pc + XLEN'(INSTR_BYTES);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc           <= RESET_PC;
      misalign_err <= 1'b0;
    end else begin
      // A redirect beats a stall: the stalled instruction is on the wrong path.
      if (redirect_valid) begin
        pc <= {redirect_target[XLEN-1:2], 2'b00};
      end else if (!stall) begin
        pc <= pc_plus4;
      end
      // Sticky until reset; the target is still used with its low bits cleared.
      if (redirect_valid && (redirect_target[1:0] != 2'b00)) begin
        misalign_err <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Purpose: MIPS instruction fetch; drives imem, registers instruction and PC+4 into IF/ID.
// Latency: instruction at pc appears on if_id_* one edge after it is presented.
// Backpressure: stall holds pc and IF/ID; redirect/flush squash IF/ID to a bubble.
// Ports: clk, rst_n, stall, flush, redirect_valid/target, imem_rdata in |
//        imem_addr, if_id_instr, if_id_pc4, if_id_valid, misalign_err, fetch_count out.
module fetch_stage
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = mips_pkg::NOP_INSTR,
  parameter int          CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic             flush,
  input  logic             redirect_valid,
  input  logic [31:0]      redirect_target,
  output logic [31:0]      imem_addr,
  input  logic [31:0]      imem_rdata,
  output logic [31:0]      if_id_instr,
  output logic [31:0]      if_id_pc4,
  output logic             if_id_valid,
  output logic             misalign_err,
  output logic [CNT_W-1:0] fetch_count
);

  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        squash;
  logic        load;
  if_id_t      if_id_q;

  pc_reg #(
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk             (clk),
    .rst_n           (rst_n),
    .stall           (stall),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .pc              (pc),
    .pc_plus4        (pc_plus4),
    .misalign_err    (misalign_err)
  );

  assign imem_addr = pc;

  // imem_rdata is only sampled on a load edge, so an X from memory on a
  // squashed or stalled cycle never reaches decode.
  assign squash = redirect_valid | flush;
  assign load   = !squash && !stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_id_q     <= '{instr: NOP_INSTR, pc4: '0, valid: 1'b0};
      fetch_count <= '0;
    end else if (squash) begin
      if_id_q     <= '{instr: NOP_INSTR, pc4: '0, valid: 1'b0};
    end else if (load) begin
      if_id_q     <= '{instr: imem_rdata, pc4: pc_plus4, valid: 1'b1};
      fetch_count <= fetch_count + 1'b1;
    end
  end

  assign if_id_instr = if_id_q.instr;
  assign if_id_pc4   = if_id_q.pc4;
  assign if_id_valid = if_id_q.valid;

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_target = 32'h0;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc4;
  logic        if_id_valid;
  logic        misalign_err;
  logic [15:0] fetch_count;

  int ntests = 0;
  int nfail  = 0;

  // Reference state, tracked from the architectural rules.
  logic [31:0] m_pc, m_instr, m_pc4;
  logic        m_valid, m_err;
  int unsigned m_cnt;

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .stall           (stall),
    .flush           (flush),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .imem_addr       (imem_addr),
    .imem_rdata      (imem_rdata),
    .if_id_instr     (if_id_instr),
    .if_id_pc4       (if_id_pc4),
    .if_id_valid     (if_id_valid),
    .misalign_err    (misalign_err),
    .fetch_count     (fetch_count)
  );

  function automatic logic [31:0] memf(input logic [31:0] a);
    case (a)
      32'h0000_0000: memf = 32'h8C01_0007;
      32'h0000_0004: memf = 32'h2021_0001;
      32'h0000_0008: memf = 32'hAC01_0002;
      default:       memf = (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endcase
  endfunction

  assign imem_rdata = memf(imem_addr);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".addr"},  imem_addr, m_pc);
    chk({tag, ".instr"}, if_id_instr, m_instr);
    chk({tag, ".pc4"},   if_id_pc4, m_pc4);
    chk({tag, ".valid"}, {31'b0, if_id_valid}, {31'b0, m_valid});
    chk({tag, ".err"},   {31'b0, misalign_err}, {31'b0, m_err});
    chk({tag, ".cnt"},   {16'b0, fetch_count}, m_cnt & 32'hFFFF);
  endtask

  task automatic model_reset();
    m_pc = 32'h0; m_instr = 32'h0; m_pc4 = 32'h0;
    m_valid = 1'b0; m_err = 1'b0; m_cnt = 0;
  endtask

  // One clock edge with the given controls; inputs are driven away from the edge.
  task automatic step(input string tag, input logic st, input logic fl,
                      input logic rv, input logic [31:0] rt);
    stall = st; flush = fl; redirect_valid = rv; redirect_target = rt;
    #1;
    chk({tag, ".pre_addr"}, imem_addr, m_pc);
    @(posedge clk);
    #1;
    if (rv && rt[1:0] != 2'b00) m_err = 1'b1;
    if (rv || fl) begin
      m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
    end else if (!st) begin
      m_instr = memf(m_pc); m_pc4 = m_pc + 32'd4; m_valid = 1'b1; m_cnt++;
    end
    if (rv)       m_pc = rt & ~32'h3;
    else if (!st) m_pc = m_pc + 32'd4;
    chk_all(tag);
    stall = 1'b0; flush = 1'b0; redirect_valid = 1'b0;
  endtask

  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    #1;
    model_reset();
    chk_all(tag);
    @(posedge clk);
    #2;
    stall = 1'b0; flush = 1'b0; redirect_valid = 1'b0; redirect_target = 32'h0;
    rst_n = 1'b1;
  endtask

  initial begin
    model_reset();
    #2;
    do_reset("rst0");

    // Free run from reset over the three-word program.
    step("run1", 0, 0, 0, 32'h0);
    chk("run1.k", if_id_instr, 32'h8C01_0007);
    step("run2", 0, 0, 0, 32'h0);
    chk("run2.k", if_id_instr, 32'h2021_0001);
    step("run3", 0, 0, 0, 32'h0);
    chk("run3.k", if_id_instr, 32'hAC01_0002);
    chk("run3.kpc4", if_id_pc4, 32'd12);
    chk("run3.kcnt", {16'b0, fetch_count}, 32'd3);

    // Two-cycle stall while pc=4.
    do_reset("rst1");
    step("s0", 0, 0, 0, 32'h0);
    step("st1", 1, 0, 0, 32'h0);
    step("st2", 1, 0, 0, 32'h0);
    chk("st2.kpc", imem_addr, 32'h4);
    chk("st2.kinstr", if_id_instr, 32'h8C01_0007);
    step("s_res", 0, 0, 0, 32'h0);
    chk("s_res.k", if_id_instr, 32'h2021_0001);

    // Redirect to 0x40 taken at pc=8.
    step("rd0", 1, 1, 1, 32'h0000_0040);
    chk("rd0.kpc", imem_addr, 32'h40);
    step("rd1", 0, 0, 0, 32'h0);
    chk("rd1.kpc4", if_id_pc4, 32'h44);

    // Redirect together with stall: redirect wins.
    step("rds", 1, 0, 1, 32'h0000_0020);
    chk("rds.kpc", imem_addr, 32'h20);

    // Misaligned target.
    step("mis", 0, 0, 1, 32'h0000_0013);
    chk("mis.kpc", imem_addr, 32'h10);
    chk("mis.kerr", {31'b0, misalign_err}, 32'h1);
    step("flush", 0, 1, 0, 32'h0);

    // Randomized controls against the reference model.
    for (int i = 0; i < 300; i++) begin
      logic st, fl, rv;
      logic [31:0] rt;
      st = ($urandom_range(0, 3) == 0);
      fl = ($urandom_range(0, 7) == 0);
      rv = ($urandom_range(0, 7) == 0);
      rt = $urandom();
      if ($urandom_range(0, 1) == 1) rt[1:0] = 2'b00;
      step("rnd", st, fl, rv, rt);
    end

    do_reset("rst2");
    chk("rst2.kerr", {31'b0, misalign_err}, 32'h0);

    // Address-space wrap.
    step("wr0", 0, 0, 1, 32'hFFFF_FFFC);
    step("wr1", 0, 0, 0, 32'h0);
    chk("wr1.kpc", imem_addr, 32'h0);
    chk("wr1.kpc4", if_id_pc4, 32'h0);
    chk("wr1.kvld", {31'b0, if_id_valid}, 32'h1);

    // Reset asserted mid-stall takes effect immediately.
    step("ms0", 0, 0, 0, 32'h0);
    stall = 1'b1;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    model_reset();
    chk_all("async");
    chk("async.kvld", {31'b0, if_id_valid}, 32'h0);
    @(posedge clk);
    #2;
    stall = 1'b0;
    rst_n = 1'b1;
    step("post", 0, 0, 0, 32'h0);
    chk("post.k", if_id_instr, 32'h8C01_0007);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
